freq_measure_core: RTL and testbench

//   Equal-precision (reciprocal) frequency counter feeding the freq_maesure AXI4-Lite register file.

---
 rtl/freq_measure_core.sv | 143 ++++++++++++++
 tb/tb_freq_measure_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_measure_core.sv
// Reciprocal frequency counter core: counts sig_in periods and ACLK cycles over a gate
// that opens and closes on sig_in rising edges, so the gate always spans whole input periods.
module freq_measure_core #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    input  logic [CNT_W-1:0] gate_cycles,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic [CNT_W-1:0] sig_count,
    output logic [CNT_W-1:0] ref_count,
    output logic             done,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, ARM, MEAS, CLOSE, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sig_edge;
    logic [CNT_W-1:0]       gate_q, tmo_q, g_q, sc_q, tc_q;
    logic [CNT_W-1:0]       g_inc;
    logic                   g_sat, tmo_hit, running;
    logic                   load, open_gate, capture, abort;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign g_inc    = g_q + ONE;
    assign g_sat    = (g_q == CMAX);
    assign running  = (state_q == ARM) || (state_q == MEAS) || (state_q == CLOSE);
    assign tmo_hit  = (tmo_q != '0) && !sig_edge && ((tc_q + ONE) == tmo_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        open_gate = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = ARM;
            end
            ARM: begin
                if (sig_edge) begin
                    open_gate = 1'b1;
                    state_d   = MEAS;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            MEAS: begin
                if (tmo_hit || g_sat) begin
                    abort = 1'b1;
                end else if (g_inc >= gate_q) begin
                    // An edge landing exactly on the gate length closes the gate at once.
                    if (sig_edge) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CLOSE;
                    end
                end
            end
            CLOSE: begin
                if (tmo_hit || g_sat) begin
                    abort = 1'b1;
                end else if (sig_edge) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = cont ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            gate_q      <= '0;
            tmo_q       <= '0;
            g_q         <= '0;
            sc_q        <= '0;
            tc_q        <= '0;
            sig_count   <= '0;
            ref_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (load) begin
                gate_q      <= (gate_cycles == '0) ? ONE : gate_cycles;
                tmo_q       <= timeout_cycles;
                timeout_err <= 1'b0;
            end
            if (abort) timeout_err <= 1'b1;

            if (!running || sig_edge) tc_q <= '0;
            else if (tc_q != CMAX)    tc_q <= tc_q + ONE;

            if (open_gate) begin
                g_q  <= '0;
                sc_q <= '0;
            end else begin
                if ((state_q == MEAS || state_q == CLOSE) && !g_sat) g_q <= g_inc;
                if (state_q == MEAS && sig_edge && sc_q != CMAX) sc_q <= sc_q + ONE;
            end

            if (capture) begin
                sig_count <= (sc_q == CMAX) ? CMAX : sc_q + ONE;
                ref_count <= g_inc;
            end
        end
    end

    assign done = (state_q == DONE);
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_freq_measure_core.sv
// Directed bench for freq_measure_core: gate alignment, timeout, continuous mode,
// ignored restarts and mid-run reset, with hand-computed expected results.
module tb_freq_measure_core;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        sig_in;
    logic        start;
    logic        cont;
    logic [31:0] gate_cycles;
    logic [31:0] timeout_cycles;
    logic [31:0] sig_count;
    logic [31:0] ref_count;
    logic        done;
    logic        busy;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int div   = 0;
    int ph    = 0;

    freq_measure_core #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .sig_in        (sig_in),
        .start         (start),
        .cont          (cont),
        .gate_cycles   (gate_cycles),
        .timeout_cycles(timeout_cycles),
        .sig_count     (sig_count),
        .ref_count     (ref_count),
        .done          (done),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    // Square wave of period div ACLK cycles; div==0 holds sig_in low.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge ACLK);
            if (div == 0) begin
                sig_in = 1'b0;
                ph     = 0;
            end else begin
                ph     = (ph + 1) % div;
                sig_in = (ph < div / 2);
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bit seen;
        int n;

        ARESET         = 1'b1;
        start          = 1'b0;
        cont           = 1'b0;
        gate_cycles    = 32'd0;
        timeout_cycles = 32'd0;
        repeat (3) tick();
        check("rst_sig_count",   sig_count, 32'd0);
        check("rst_ref_count",   ref_count, 32'd0);
        check("rst_done",        32'(done), 32'd0);
        check("rst_busy",        32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        ARESET = 1'b0;

        // 1: ACLK/4, gate 100 -> exactly 25 periods in 100 cycles
        div            = 4;
        gate_cycles    = 32'd100;
        timeout_cycles = 32'd1000;
        repeat (10) tick();
        pulse_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done(300, seen, n);
        check("t1_done_seen", 32'(seen), 32'd1);
        check("t1_sig_count", sig_count, 32'd25);
        check("t1_ref_count", ref_count, 32'd100);
        tick();
        check("t1_busy_falls", 32'(busy), 32'd0);
        check("t1_done_falls", 32'(done), 32'd0);

        // 2: gate 101 stretches to the next whole period at 104
        gate_cycles = 32'd101;
        pulse_start();
        wait_done(300, seen, n);
        check("t2_done_seen", 32'(seen), 32'd1);
        check("t2_sig_count", sig_count, 32'd26);
        check("t2_ref_count", ref_count, 32'd104);

        // 3: static input, timeout 50 -> abort after 50 ARM cycles, results held
        div = 0;
        repeat (10) tick();
        gate_cycles    = 32'd100;
        timeout_cycles = 32'd50;
        pulse_start();
        seen = 1'b0;
        n    = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        check("t3_cycles_to_idle", 32'(n), 32'd50);
        check("t3_no_done",        32'(seen), 32'd0);
        check("t3_timeout_err",    32'(timeout_err), 32'd1);
        check("t3_sig_held",       sig_count, 32'd26);
        check("t3_ref_held",       ref_count, 32'd104);

        // 4: continuous mode, ACLK/10, gate 1000
        div            = 10;
        gate_cycles    = 32'd1000;
        timeout_cycles = 32'd0;
        cont           = 1'b1;
        repeat (20) tick();
        pulse_start();
        check("t4_timeout_err_cleared", 32'(timeout_err), 32'd0);
        wait_done(1200, seen, n);
        check("t4_done1_seen", 32'(seen), 32'd1);
        check("t4_sig1",       sig_count, 32'd100);
        check("t4_ref1",       ref_count, 32'd1000);
        wait_done(1200, seen, n);
        check("t4_done2_seen",  32'(seen), 32'd1);
        check("t4_done_period", 32'(n), 32'd1010);
        check("t4_sig2",        sig_count, 32'd100);
        check("t4_ref2",        ref_count, 32'd1000);
        repeat (5) tick();
        cont = 1'b0;
        check("t4_busy_in_last_run", 32'(busy), 32'd1);
        wait_done(1200, seen, n);
        check("t4_done3_seen", 32'(seen), 32'd1);
        check("t4_sig3",       sig_count, 32'd100);
        check("t4_ref3",       ref_count, 32'd1000);
        tick();
        check("t4_idle_after_last", 32'(busy), 32'd0);
        wait_done(1100, seen, n);
        check("t4_no_extra_done", 32'(seen), 32'd0);

        // 5: restart mid-run with gate 5 is ignored; start in the DONE cycle is ignored
        div         = 4;
        gate_cycles = 32'd100;
        repeat (10) tick();
        pulse_start();
        repeat (20) tick();
        gate_cycles = 32'd5;
        pulse_start();
        check("t5_busy_after_restart", 32'(busy), 32'd1);
        wait_done(300, seen, n);
        check("t5_done_seen", 32'(seen), 32'd1);
        check("t5_sig_count", sig_count, 32'd25);
        check("t5_ref_count", ref_count, 32'd100);
        pulse_start();
        check("t5_start_in_done_ignored", 32'(busy), 32'd0);

        // 6: reset during CLOSE, then a clean repeat of test 1
        gate_cycles = 32'd101;
        pulse_start();
        n = 0;
        while (dut.state_q != 3'd3 && n < 300) begin
            tick();
            n++;
        end
        check("t6_reached_close", 32'(n < 300), 32'd1);
        ARESET = 1'b1;
        tick();
        check("t6_rst_sig_count",   sig_count, 32'd0);
        check("t6_rst_ref_count",   ref_count, 32'd0);
        check("t6_rst_done",        32'(done), 32'd0);
        check("t6_rst_busy",        32'(busy), 32'd0);
        check("t6_rst_timeout_err", 32'(timeout_err), 32'd0);
        ARESET      = 1'b0;
        gate_cycles = 32'd100;
        repeat (5) tick();
        pulse_start();
        wait_done(300, seen, n);
        check("t6_done_seen", 32'(seen), 32'd1);
        check("t6_sig_count", sig_count, 32'd25);
        check("t6_ref_count", ref_count, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
